ctrl_unit_pipe: RTL and testbench
=================================

// Module: ctrl_unit_pipe
// PURPOSE
//   Pipelined successor to the combinational control decoder. Decodes op/func
//   into datapath controls, carries them through a STAGES-deep control pipe
//   with stall/flush, and traps illegal op/func and HALT in a RUN/EXC/HALTED FSM.
//   Sits between fetch/IF-ID and the execute datapath; gates fetch via fetch_en.
// PARAMETERS
//   OP_W    4   opcode width; bits above [3:0] must be 0, else illegal opcode
//   FN_W    4   func width; bits above [3:0] must be 0, else illegal func
//   PC_W    16  PC width captured on exception
//   STAGES  1   control pipe depth, 1..3; outputs lag accepted input by STAGES
// PORTS
//   clk         in   1     clock, rising edge
//   rst_n       in   1     async active-low reset
//   in_valid    in   1     op_code/func_code/pc_in valid this cycle
//   op_code     in   OP_W  instruction opcode
//   func_code   in   FN_W  Type-A function code
//   pc_in       in   PC_W  PC of presented instruction
//   stall       in   1     hold all pipe stages, accept nothing
//   flush       in   1     squash all stages to bubbles (wins over stall)
//   exc_ack     in   1     leave EXC (ignored in other states)
//   restart     in   1     leave HALTED (ignored in other states)
//   fetch_en    out  1     (state==RUN) & !stall
//   out_valid   out  1     last stage holds a real instruction
//   inst_type   out  2     00 A, 01 B, 10 C, 11 D
//   wr, wr_r15, mem_to_reg, mem_read, mem_write, alu_src, alu_op  out 1 each
//   branch      out  3     000 none,100 BGE,101 BLE,110 BEQ,111 JMP
//   exc_flag    out  1     sticky exception pending
//   exc_cause   out  2     01 bad opcode, 10 bad func, 00 none
//   exc_pc      out  PC_W  pc_in of trapping instruction
//   halted      out  1     state==HALTED
// BEHAVIOUR
//   Decode (op[3:0]): 0000 A-ALU type00 wr=1; func {0-3,8-B} ok, 4/5 also wr_r15=1,
//     else bad func. 0100/0101/0110 BGE/BLE/BEQ type10 branch 100/101/110.
//     1000 ANDi, 1001 ORi type10 wr=1 alu_src=1. 1010 LW type01 wr mem_read
//     mem_to_reg alu_src alu_op=1. 1011 SW type01 mem_write alu_src alu_op=1.
//     1100 JMP type11 branch 111. 1111 HALT type11, all controls 0. Else bad op.
//     Unlisted controls 0.
//   Accept = in_valid & !stall & !flush & state==RUN. Accepted legal instr enters
//     stage 0; illegal enters as bubble. Stages shift every cycle unless stall.
//   out_valid=0 forces every control output to 0; inst_type 00 on bubble.
//   flush: all stage valids clear at next edge; same-cycle accept discarded,
//     no exception, no HALT transition.
//   FSM RUN: illegal accept -> EXC, exc_flag=1, exc_cause, exc_pc=pc_in next edge.
//     HALT accept -> HALTED (HALT itself flows down pipe as valid).
//   EXC: in_valid ignored; pipe drains; exc_ack -> RUN, exc_flag/cause to 0.
//   HALTED: in_valid ignored; pipe drains; restart -> RUN.
//   exc_ack/restart with stall still act; flush never changes FSM state.
//   Reset (async, any time): state RUN, all stage valids 0, all outputs 0,
//     exc_pc 0; fetch_en = !stall during/after reset.
// TESTING
//   STAGES=2: LW at cycle 0, no stall -> cycle 2 out_valid=1 wr=1 mem_read=1
//     mem_to_reg=1 alu_src=1 alu_op=1 inst_type=01.
//   op 0000 func 0101 then stall 3 cycles -> wr=1 wr_r15=1 held 3 extra cycles.
//   op 0000 func 0110 pc=16'h0040 -> exc_flag=1 cause=10 exc_pc=0040, fetch_en=0,
//     no out_valid for it; exc_ack -> RUN next cycle, cause=00.
//   op 1101 with flush same cycle -> no exception, state RUN, bubble only.
//   HALT followed by BEQ -> halted=1, BEQ ignored; restart -> fetch_en=1.
//   Assert rst_n low mid-EXC with full pipe -> all outputs 0 immediately, RUN.

Source files
------------

// File: rtl/ctrl_unit_pipe.sv
// ctrl_unit_pipe
//   Pipelined control decoder. Decodes op_code/func_code into datapath
//   controls, carries them through a STAGES-deep control pipe that honours
//   stall and flush, and traps illegal instructions and HALT in a small
//   RUN / EXC / HALTED state machine that also gates instruction fetch.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   in_valid          op_code / func_code / pc_in carry an instruction
//   op_code, func_code, pc_in   instruction fields and its PC
//   stall             freeze every pipe stage, accept nothing
//   flush             squash every stage to a bubble (wins over stall)
//   exc_ack, restart  leave EXC / leave HALTED respectively
//   fetch_en          fetch may advance: state is RUN and no stall
//   out_valid         last stage holds a real instruction
//   inst_type, wr, wr_r15, mem_to_reg, mem_read, mem_write, alu_src,
//   alu_op, branch    datapath controls of the last stage (0 on a bubble)
//   exc_flag, exc_cause, exc_pc   pending exception, its cause and PC
//   halted            state machine is in HALTED
module ctrl_unit_pipe #(
  parameter int OP_W   = 4,
  parameter int FN_W   = 4,
  parameter int PC_W   = 16,
  parameter int STAGES = 1   // 1..3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic [OP_W-1:0] op_code,
  input  logic [FN_W-1:0] func_code,
  input  logic [PC_W-1:0] pc_in,
  input  logic            stall,
  input  logic            flush,
  input  logic            exc_ack,
  input  logic            restart,
  output logic            fetch_en,
  output logic            out_valid,
  output logic [1:0]      inst_type,
  output logic            wr,
  output logic            wr_r15,
  output logic            mem_to_reg,
  output logic            mem_read,
  output logic            mem_write,
  output logic            alu_src,
  output logic            alu_op,
  output logic [2:0]      branch,
  output logic            exc_flag,
  output logic [1:0]      exc_cause,
  output logic [PC_W-1:0] exc_pc,
  output logic            halted
);

  typedef struct packed {
    logic [1:0] instType;
    logic       wr;
    logic       wrR15;
    logic       memToReg;
    logic       memRead;
    logic       memWrite;
    logic       aluSrc;
    logic       aluOp;
    logic [2:0] branch;
  } ctrlT;

  localparam logic [1:0] RUN    = 2'b00;
  localparam logic [1:0] EXC    = 2'b01;
  localparam logic [1:0] HALTED = 2'b10;

  localparam logic [1:0] CAUSE_OP = 2'b01;
  localparam logic [1:0] CAUSE_FN = 2'b10;

  logic [1:0] state;
  ctrlT       decCtrl;
  logic       opBad, fnBad, isHalt;
  logic       opHigh, fnHigh;
  logic       illegal, accept;

  // Any set bit above the 4-bit decode field makes the code illegal.
  assign opHigh = |(op_code >> 4);
  assign fnHigh = |(func_code >> 4);

  // NOTE: every output of this block gets a default first so no path leaves
  // a value unassigned, which is what keeps it free of inferred latches.
  always_comb begin
    decCtrl = '0;
    opBad   = 1'b0;
    fnBad   = 1'b0;
    isHalt  = 1'b0;
    if (opHigh) begin
      opBad = 1'b1;
    end else begin
      case (op_code[3:0])
        4'b0000: begin                          // Type-A ALU
          decCtrl.wr = 1'b1;
          if (fnHigh) begin
            fnBad = 1'b1;
          end else begin
            case (func_code[3:0])
              4'd4, 4'd5:                                  decCtrl.wrR15 = 1'b1;
              4'd6, 4'd7, 4'd12, 4'd13, 4'd14, 4'd15:       fnBad = 1'b1;
              default: ;
            endcase
          end
        end
        4'b0100: begin decCtrl.instType = 2'b10; decCtrl.branch = 3'b100; end // BGE
        4'b0101: begin decCtrl.instType = 2'b10; decCtrl.branch = 3'b101; end // BLE
        4'b0110: begin decCtrl.instType = 2'b10; decCtrl.branch = 3'b110; end // BEQ
        4'b1000, 4'b1001: begin                 // ANDi / ORi
          decCtrl.instType = 2'b10;
          decCtrl.wr       = 1'b1;
          decCtrl.aluSrc   = 1'b1;
        end
        4'b1010: begin                          // LW
          decCtrl.instType = 2'b01;
          decCtrl.wr       = 1'b1;
          decCtrl.memRead  = 1'b1;
          decCtrl.memToReg = 1'b1;
          decCtrl.aluSrc   = 1'b1;
          decCtrl.aluOp    = 1'b1;
        end
        4'b1011: begin                          // SW
          decCtrl.instType = 2'b01;
          decCtrl.memWrite = 1'b1;
          decCtrl.aluSrc   = 1'b1;
          decCtrl.aluOp    = 1'b1;
        end
        4'b1100: begin decCtrl.instType = 2'b11; decCtrl.branch = 3'b111; end // JMP
        4'b1111: begin decCtrl.instType = 2'b11; isHalt = 1'b1; end            // HALT
        default: opBad = 1'b1;
      endcase
    end
  end

  assign illegal = opBad | fnBad;
  assign accept  = in_valid & ~stall & ~flush & (state == RUN);

  // Control pipe: a valid bit per stage plus the decoded payload.
  logic [STAGES-1:0] pipeValid;
  ctrlT              pipeCtrl [STAGES];

  // NOTE: sequential state is written with non-blocking assignments so every
  // stage samples its predecessor's pre-edge value and the shift is exact.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipeValid <= '0;
    end else if (flush) begin
      pipeValid <= '0;
    end else if (!stall) begin
      // An illegal instruction enters as a bubble.
      pipeValid[0] <= accept & ~illegal;
      for (int i = 1; i < STAGES; i++) pipeValid[i] <= pipeValid[i-1];
    end
  end

  // NOTE: the payload registers are deliberately not reset; a stage's
  // payload is only ever observed through its valid bit, which is reset.
  always_ff @(posedge clk) begin
    if (!stall && !flush) begin
      pipeCtrl[0] <= decCtrl;
      for (int i = 1; i < STAGES; i++) pipeCtrl[i] <= pipeCtrl[i-1];
    end
  end

  // Trap / halt state machine. Accept already excludes flush, and a flush
  // cycle also holds off exc_ack/restart, so flush never moves the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      exc_flag  <= 1'b0;
      exc_cause <= 2'b00;
      exc_pc    <= '0;
    end else begin
      case (state)
        RUN: begin
          if (accept && illegal) begin
            state     <= EXC;
            exc_flag  <= 1'b1;
            exc_cause <= opBad ? CAUSE_OP : CAUSE_FN;
            exc_pc    <= pc_in;
          end else if (accept && isHalt) begin
            state <= HALTED;
          end
        end
        EXC: begin
          if (exc_ack && !flush) begin
            state     <= RUN;
            exc_flag  <= 1'b0;
            exc_cause <= 2'b00;
          end
        end
        HALTED: begin
          if (restart && !flush) state <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

  ctrlT outCtrl;
  assign outCtrl = pipeValid[STAGES-1] ? pipeCtrl[STAGES-1] : '0;

  assign fetch_en   = (state == RUN) & ~stall;
  assign halted     = (state == HALTED);
  assign out_valid  = pipeValid[STAGES-1];
  assign inst_type  = outCtrl.instType;
  assign wr         = outCtrl.wr;
  assign wr_r15     = outCtrl.wrR15;
  assign mem_to_reg = outCtrl.memToReg;
  assign mem_read   = outCtrl.memRead;
  assign mem_write  = outCtrl.memWrite;
  assign alu_src    = outCtrl.aluSrc;
  assign alu_op     = outCtrl.aluOp;
  assign branch     = outCtrl.branch;

endmodule

// File: tb/tb_ctrl_unit_pipe.sv
// tb_ctrl_unit_pipe
//   Bench for ctrl_unit_pipe with a two-stage control pipe. A behavioural
//   model (instruction table + queue of in-flight slots + trap state) predicts
//   every output each cycle; directed scenarios add explicit expectations.
module tb_ctrl_unit_pipe;

  localparam int OP_W   = 4;
  localparam int FN_W   = 4;
  localparam int PC_W   = 16;
  localparam int STAGES = 2;

  logic            clk, rst_n;
  logic            in_valid, stall, flush, exc_ack, restart;
  logic [OP_W-1:0] op_code;
  logic [FN_W-1:0] func_code;
  logic [PC_W-1:0] pc_in;
  logic            fetch_en, out_valid;
  logic [1:0]      inst_type;
  logic            wr, wr_r15, mem_to_reg, mem_read, mem_write, alu_src, alu_op;
  logic [2:0]      branch;
  logic            exc_flag;
  logic [1:0]      exc_cause;
  logic [PC_W-1:0] exc_pc;
  logic            halted;

  ctrl_unit_pipe #(.OP_W(OP_W), .FN_W(FN_W), .PC_W(PC_W), .STAGES(STAGES)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .op_code(op_code),
    .func_code(func_code), .pc_in(pc_in), .stall(stall), .flush(flush),
    .exc_ack(exc_ack), .restart(restart), .fetch_en(fetch_en),
    .out_valid(out_valid), .inst_type(inst_type), .wr(wr), .wr_r15(wr_r15),
    .mem_to_reg(mem_to_reg), .mem_read(mem_read), .mem_write(mem_write),
    .alu_src(alu_src), .alu_op(alu_op), .branch(branch), .exc_flag(exc_flag),
    .exc_cause(exc_cause), .exc_pc(exc_pc), .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {inst_type, wr, wr_r15, mem_to_reg, mem_read, mem_write, alu_src, alu_op, branch}
  logic [11:0] dutCtrl;
  assign dutCtrl = {inst_type, wr, wr_r15, mem_to_reg, mem_read, mem_write,
                    alu_src, alu_op, branch};

  int nChecks = 0;
  int nErrors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    bit        v;
    bit [11:0] c;
  } slotT;

  slotT      mPipe[$];
  int        mState;      // 0 running, 1 exception, 2 halted
  bit        mExcFlag;
  bit [1:0]  mCause;
  bit [15:0] mExcPc;

  function automatic bit [11:0] mk(bit [1:0] t, bit w, bit r15, bit m2r, bit mr,
                                   bit mw, bit as, bit ao, bit [2:0] br);
    return {t, w, r15, m2r, mr, mw, as, ao, br};
  endfunction

  function automatic void refDecode(input bit [3:0] op, input bit [3:0] fn,
                                    output bit ok, output bit hlt,
                                    output bit [1:0] cause, output bit [11:0] c);
    ok = 1'b1; hlt = 1'b0; cause = 2'd0; c = '0;
    case (op)
      4'd0: begin
        c = mk(2'd0, 1, (fn == 4 || fn == 5), 0, 0, 0, 0, 0, 3'd0);
        if (!(fn <= 5 || (fn >= 8 && fn <= 11))) begin ok = 1'b0; cause = 2'd2; end
      end
      4'd4, 4'd5, 4'd6: c = mk(2'd2, 0, 0, 0, 0, 0, 0, 0, 3'd4 + 3'(op - 4'd4));
      4'd8, 4'd9:       c = mk(2'd2, 1, 0, 0, 0, 0, 1, 0, 3'd0);
      4'd10:            c = mk(2'd1, 1, 0, 1, 1, 0, 1, 1, 3'd0);
      4'd11:            c = mk(2'd1, 0, 0, 0, 0, 1, 1, 1, 3'd0);
      4'd12:            c = mk(2'd3, 0, 0, 0, 0, 0, 0, 0, 3'd7);
      4'd15: begin      c = mk(2'd3, 0, 0, 0, 0, 0, 0, 0, 3'd0); hlt = 1'b1; end
      default: begin ok = 1'b0; cause = 2'd1; end
    endcase
  endfunction

  function automatic void modelReset();
    slotT s;
    s.v = 1'b0; s.c = '0;
    mState = 0; mExcFlag = 1'b0; mCause = 2'd0; mExcPc = '0;
    mPipe.delete();
    for (int i = 0; i < STAGES; i++) mPipe.push_back(s);
  endfunction

  // Advance the model by one clock edge using the inputs currently driven.
  function automatic void modelUpdate();
    bit ok, hlt, acc;
    bit [1:0]  cause;
    bit [11:0] c;
    slotT s;
    refDecode(op_code, func_code, ok, hlt, cause, c);
    acc = in_valid && !stall && !flush && (mState == 0);
    if (flush) begin
      foreach (mPipe[i]) mPipe[i].v = 1'b0;
    end else if (!stall) begin
      s.v = acc && ok; s.c = c;
      mPipe.push_front(s);
      void'(mPipe.pop_back());
    end
    if (mState == 0 && acc) begin
      if (!ok) begin
        mState = 1; mExcFlag = 1'b1; mCause = cause; mExcPc = pc_in;
      end else if (hlt) begin
        mState = 2;
      end
    end else if (mState == 1 && exc_ack && !flush) begin
      mState = 0; mExcFlag = 1'b0; mCause = 2'd0;
    end else if (mState == 2 && restart && !flush) begin
      mState = 0;
    end
  endfunction

  task automatic compareAll();
    slotT last;
    last = mPipe[STAGES-1];
    check("out_valid", out_valid, last.v);
    check("ctrl",      dutCtrl,   last.v ? last.c : 12'd0);
    check("exc_flag",  exc_flag,  mExcFlag);
    check("exc_cause", exc_cause, mCause);
    check("exc_pc",    exc_pc,    mExcPc);
    check("halted",    halted,    mState == 2);
    check("fetch_en",  fetch_en,  (mState == 0) && !stall);
  endtask

  // Inputs are driven 1 time unit after the rising edge; outputs are
  // compared at that same point, well clear of the next edge.
  task automatic step();
    @(posedge clk);
    if (rst_n) modelUpdate();
    #1;
    compareAll();
  endtask

  task automatic present(input logic v, input logic [3:0] op, input logic [3:0] fn,
                         input logic [15:0] pc);
    in_valid = v; op_code = op; func_code = fn; pc_in = pc;
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0; exc_ack = 1'b0; restart = 1'b0;
    present(1'b0, 4'd0, 4'd0, 16'd0);
    modelReset();

    // Reset state before any clock edge.
    #2;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_fetch_en",  fetch_en,  1'b1);
    compareAll();
    step(); step();
    rst_n = 1'b1;

    // LW: out_valid two edges later with load controls.
    present(1'b1, 4'b1010, 4'd0, 16'h0001);
    step();
    present(1'b0, 4'd0, 4'd0, 16'd0);
    step();
    check("lw_valid", out_valid, 1'b1);
    check("lw_ctrl",  dutCtrl,   12'b01_1_0_1_1_0_1_1_000);
    step();

    // ALU func 0101 held for three stall cycles.
    present(1'b1, 4'b0000, 4'b0101, 16'h0002);
    step();
    present(1'b0, 4'd0, 4'd0, 16'd0);
    step();
    check("r15_out", {out_valid, wr, wr_r15}, 3'b111);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("r15_hold", {out_valid, wr, wr_r15}, 3'b111);
    end
    stall = 1'b0;
    step();
    check("r15_drain", out_valid, 1'b0);

    // Bad func traps; instruction offered during EXC is ignored.
    present(1'b1, 4'b0000, 4'b0110, 16'h0040);
    step();
    present(1'b0, 4'd0, 4'd0, 16'd0);
    check("bf_flag",  exc_flag,  1'b1);
    check("bf_cause", exc_cause, 2'b10);
    check("bf_pc",    exc_pc,    16'h0040);
    check("bf_fetch", fetch_en,  1'b0);
    step();
    check("bf_novalid", out_valid, 1'b0);
    present(1'b1, 4'b0000, 4'b0001, 16'h0044);
    step();
    check("bf_novalid2", out_valid, 1'b0);
    present(1'b0, 4'd0, 4'd0, 16'd0);
    exc_ack = 1'b1;
    step();
    exc_ack = 1'b0;
    check("ack_flag",  exc_flag,  1'b0);
    check("ack_cause", exc_cause, 2'b00);
    check("ack_fetch", fetch_en,  1'b1);
    step(); step();
    check("ack_ignored", out_valid, 1'b0);

    // Illegal op with flush in the same cycle: no trap.
    present(1'b1, 4'b1101, 4'd0, 16'h0050);
    flush = 1'b1;
    step();
    flush = 1'b0;
    present(1'b0, 4'd0, 4'd0, 16'd0);
    check("fl_flag",  exc_flag, 1'b0);
    check("fl_fetch", fetch_en, 1'b1);
    step();
    check("fl_bubble", out_valid, 1'b0);

    // HALT then BEQ: HALT flows out, BEQ never does; restart resumes.
    present(1'b1, 4'b1111, 4'd0, 16'h0060);
    step();
    check("h_halted", halted,   1'b1);
    check("h_fetch",  fetch_en, 1'b0);
    present(1'b1, 4'b0110, 4'd0, 16'h0062);
    step();
    present(1'b0, 4'd0, 4'd0, 16'd0);
    check("h_out", {out_valid, dutCtrl}, {1'b1, 12'b11_0000000_000});
    step(); step();
    check("h_beq_ignored", out_valid, 1'b0);
    restart = 1'b1;
    step();
    restart = 1'b0;
    check("h_restart_fetch", fetch_en, 1'b1);
    check("h_restart_halt",  halted,   1'b0);

    // Async reset in EXC with a valid instruction at the output.
    for (int i = 0; i < 3; i++) begin
      present(1'b1, 4'b0000, 4'(i), 16'(16'h0070 + i));
      step();
    end
    present(1'b1, 4'b0111, 4'd0, 16'h0080);
    step();
    present(1'b0, 4'd0, 4'd0, 16'd0);
    check("pre_rst_flag",  exc_flag,  1'b1);
    check("pre_rst_cause", exc_cause, 2'b01);
    check("pre_rst_valid", out_valid, 1'b1);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_outs", {out_valid, dutCtrl, exc_flag, exc_cause, exc_pc, halted},
          32'd0);
    check("async_rst_fetch", fetch_en, 1'b1);
    modelReset();
    compareAll();
    step();
    rst_n = 1'b1;

    // Randomized traffic against the model.
    for (int n = 0; n < 700; n++) begin
      flush    = ($urandom % 12) == 0;
      stall    = ($urandom % 5) == 0;
      exc_ack  = !flush && (($urandom % 4) == 0);
      restart  = !flush && (($urandom % 4) == 0);
      present(($urandom % 4) != 0, 4'($urandom_range(0, 15)),
              4'($urandom_range(0, 15)), 16'($urandom));
      step();
    end

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
